rr_arb_mux: RTL and testbench
=============================

# rr_arb_mux

Parametrised N-channel, WIDTH-bit arbitrating multiplexer with valid/ready handshakes and a registered output. It is the next generation of the datapath selection muxes: channel choice comes from a fixed-priority or round-robin arbiter instead of an external select. It sits where several producers share one consumer, such as write-back sources or memory-request ports feeding a single stage. One output register decouples timing and gives 1-cycle latency at full throughput.

## Interface
- WIDTH, 32, data width per channel (>=1)
- N, 3, number of input channels (2..16)
- MODE, ARB_RR, arbitration mode: ARB_FIXED (channel 0 highest) or ARB_RR (round robin)
- SEL_W, $clog2(N), width of out_sel (derived, not overridden)

- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  N  per-channel request
- in_ready  out  N  per-channel accept, at most one bit set
- out_data  out  WIDTH  registered selected data
- out_valid  out  1  out_data holds an undelivered word
- out_ready  in  1  consumer accepts out_data
- out_sel  out  SEL_W  index of channel that supplied out_data

## Operation
- Reset values: out_valid=0, out_data=0, out_sel=0, rr pointer ptr=0; in_ready=0 while rst_n low.
- load = !out_valid || out_ready (output register free or draining this cycle).
- Grant g is computed combinationally from in_valid each cycle:
  - ARB_FIXED: g = lowest index i with in_valid[i].
  - ARB_RR: g = first i with in_valid[i], searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (mod N).
- in_ready[g] = load && any(in_valid); all other in_ready bits are 0. in_ready never depends on out_valid of other channels.
- Transfer in on channel g when in_valid[g] && in_ready[g]: at the next edge out_data<=in_data[g], out_sel<=g, out_valid<=1; in ARB_RR ptr <= (g+1) mod N (wrap from N-1 to 0).
- Output drain when out_valid && out_ready with no new transfer: out_valid<=0; out_data and out_sel hold their last value.
- Simultaneous drain and transfer: the new word replaces the old in the same edge, out_valid stays 1.
- Stall (out_valid && !out_ready): out_data, out_sel, and ptr are frozen, and all in_ready are 0.
- ptr advances only on an accepted transfer, never on requests that were not granted.
- A source may drop in_valid without a transfer; the arbiter re-evaluates each cycle and no grant is latched.
- ARB_FIXED: ptr exists but is ignored and stays 0.

## Timing
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 word/cycle sustained when out_ready is held high.
- Combinational paths: in_valid → in_ready and out_ready → in_ready. There is no path from in_data to any output in the same cycle.
- Reset mid-operation: on rst_n fall, out_valid drops immediately (async) and the in-flight word is discarded. The first grant after release goes to channel 0 if it is valid.
- ARB_RR fairness: with all N channels continuously valid and out_ready=1, grants cycle 0,1,...,N-1,0. Any valid channel waits at most N-1 transfers.

## Structure
- Package arb_pkg holds:
  - arbitration mode constants ARB_FIXED=0, ARB_RR=1;
  - a function for the SEL_W computation, shared by any future arbiters.
- Sub-module rr_priority_pick (parameter N):
  - purely combinational;
  - inputs req[N] and ptr[SEL_W];
  - outputs one-hot gnt[N], encoded idx, and any;
  - implemented by double-width request masking (req concatenated with itself, shifted by ptr).
- rr_arb_mux holds the output register, ptr, handshake logic, and the WIDTH-wide one-hot data select.

## Test plan
- Reset and idle: rst_n=0, then 1 with in_valid=0 → out_valid=0, out_data=0, out_sel=0, in_ready=0 for 10 cycles.
- Single channel (N=3, WIDTH=32, ARB_RR): in_valid=3'b010, in_data[1]=9, out_ready=1 → in_ready=3'b010; next cycle out_data=9, out_valid=1, out_sel=1.
- Round-robin rotation: all valid with data 5, 9, 12, out_ready=1 for 6 cycles → out_data sequence 5, 9, 12, 5, 9, 12 and out_sel 0, 1, 2, 0, 1, 2.
- Fixed priority (MODE=ARB_FIXED), all valid for 4 cycles → out_sel stays 0 and in_ready[2:1]=0 throughout.
- Backpressure: hold out_ready=0 for 3 cycles after out_data=9 is loaded → out_data=9 and out_sel=1 stay stable, in_ready=0, and ptr is unchanged. When out_ready=1, the next grant goes to channel 2.
- Async reset mid-stream: assert rst_n low between edges while out_valid=1 → out_valid=0 immediately. After release with all channels valid, the first out_sel=0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared arbitration constants and helpers for the arbitrating mux family.
// Any future arbiter sizes its index ports with sel_width() so they all agree.
package arb_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Index width for n channels; a single channel still needs a 1-bit port.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating priority picker: first set request at or after ptr,
// wrapping modulo N. With ptr tied to 0 it is a plain lowest-index-first picker.
module rr_priority_pick
    import arb_pkg::*;
#(
    parameter int N = 3,
    localparam int SEL_W = sel_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    localparam logic [SEL_W:0] N_EXT = (SEL_W + 1)'(N);

    logic [N-1:0]   rot;
    logic [SEL_W:0] off;
    logic [SEL_W:0] sum;
    logic           found;

    // Requests rotated so that bit 0 is channel ptr; doubling the vector
    // makes the wrap-around fall out of a plain right shift.
    assign rot = N'({req, req} >> ptr);

    // NOTE: every variable written here gets a default before any condition,
    // otherwise an unassigned path would infer a latch.
    always_comb begin
        off   = '0;
        found = 1'b0;
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) begin
                off   = (SEL_W + 1)'(j);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        sum = {1'b0, ptr} + off;
        if (sum >= N_EXT) begin
            sum = sum - N_EXT;
        end
    end

    assign idx = sum[SEL_W-1:0];
    assign gnt = found ? (N'(1) << idx) : '0;
    assign any = |req;

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel arbitrating multiplexer with valid/ready handshakes and one output
// register: 1-cycle latency, full throughput when out_ready is held high.
module rr_arb_mux
    import arb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 3,
    parameter int MODE  = ARB_RR,
    localparam int SEL_W = sel_width(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SEL_W-1:0]   out_sel
);

    localparam logic [SEL_W-1:0] LAST = SEL_W'(N - 1);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] pick_ptr;
    logic [N-1:0]     gnt;
    logic [SEL_W-1:0] g_idx;
    logic             any;
    logic             load;
    logic             xfer;
    logic [WIDTH-1:0] sel_data;

    // Fixed priority is the same picker with the search always starting at 0.
    assign pick_ptr = (MODE == ARB_RR) ? ptr : '0;

    rr_priority_pick #(
        .N (N)
    ) u_pick (
        .req (in_valid),
        .ptr (pick_ptr),
        .gnt (gnt),
        .idx (g_idx),
        .any (any)
    );

    // Output register is free, or its word leaves on this edge.
    assign load     = !out_valid || out_ready;
    assign in_ready = (rst_n && load && any) ? gnt : '0;
    assign xfer     = |(in_ready & in_valid);

    // One-hot AND-OR select keeps the data path free of a wide index decode.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            sel_data |= in_data[i*WIDTH +: WIDTH] & {WIDTH{gnt[i]}};
        end
    end

    // NOTE: out_data is reset so an idle output reads 0; a wide data register
    // would otherwise be left without reset since out_valid qualifies it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_sel   <= g_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (xfer && (MODE == ARB_RR)) begin
            ptr <= (g_idx == LAST) ? '0 : g_idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Scoreboard bench for rr_arb_mux: one round-robin and one fixed-priority
// instance, directed stimulus pushing hand-computed words, monitors popping.
module tb_rr_arb_mux;
    import arb_pkg::*;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  sel;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [95:0] in_data;

    logic [2:0]  rr_in_valid, rr_in_ready;
    logic [31:0] rr_out_data;
    logic        rr_out_valid, rr_out_ready;
    logic [1:0]  rr_out_sel;

    logic [2:0]  fx_in_valid, fx_in_ready;
    logic [31:0] fx_out_data;
    logic        fx_out_valid, fx_out_ready;
    logic [1:0]  fx_out_sel;

    exp_t rr_q[$];
    exp_t fx_q[$];
    exp_t rr_e, fx_e;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [31:0] dv [3] = '{32'd5, 32'd9, 32'd12};

    always #5 clk = ~clk;

    rr_arb_mux #(.WIDTH(32), .N(3), .MODE(ARB_RR)) dut_rr (
        .clk(clk), .rst_n(rst_n), .in_data(in_data),
        .in_valid(rr_in_valid), .in_ready(rr_in_ready),
        .out_data(rr_out_data), .out_valid(rr_out_valid),
        .out_ready(rr_out_ready), .out_sel(rr_out_sel)
    );

    rr_arb_mux #(.WIDTH(32), .N(3), .MODE(ARB_FIXED)) dut_fx (
        .clk(clk), .rst_n(rst_n), .in_data(in_data),
        .in_valid(fx_in_valid), .in_ready(fx_in_ready),
        .out_data(fx_out_data), .out_valid(fx_out_valid),
        .out_ready(fx_out_ready), .out_sel(fx_out_sel)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitors: a word is delivered when valid and ready meet at an edge.
    always @(negedge clk) begin
        if (rst_n && rr_out_valid && rr_out_ready) begin
            if (rr_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL rr_unexpected: got data %0d sel %0d expected no word", rr_out_data, rr_out_sel);
            end else begin
                rr_e = rr_q.pop_front();
                check("rr_data", rr_out_data, rr_e.data);
                check("rr_sel", 32'(rr_out_sel), 32'(rr_e.sel));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && fx_out_valid && fx_out_ready) begin
            if (fx_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL fx_unexpected: got data %0d sel %0d expected no word", fx_out_data, fx_out_sel);
            end else begin
                fx_e = fx_q.pop_front();
                check("fx_data", fx_out_data, fx_e.data);
                check("fx_sel", 32'(fx_out_sel), 32'(fx_e.sel));
            end
        end
    end

    initial begin
        rst_n        = 1'b0;
        in_data      = {32'd12, 32'd9, 32'd5};
        rr_in_valid  = 3'b111;
        rr_out_ready = 1'b0;
        fx_in_valid  = 3'b000;
        fx_out_ready = 1'b0;

        // In reset a valid request must still see no ready.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", 32'(rr_in_ready), 0);
        check("reset_out_valid", 32'(rr_out_valid), 0);
        rr_in_valid = 3'b000;
        step();
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_out_valid", 32'(rr_out_valid), 0);
            check("idle_out_data", rr_out_data, 0);
            check("idle_out_sel", 32'(rr_out_sel), 0);
            check("idle_in_ready", 32'(rr_in_ready), 0);
            step();
        end

        // Single request on channel 1.
        rr_in_valid  = 3'b010;
        rr_out_ready = 1'b1;
        rr_q.push_back('{data: 32'd9, sel: 2'd1});
        @(negedge clk);
        check("single_in_ready", 32'(rr_in_ready), 2);
        step();

        // Backpressure: word 9 held, no grants, ptr frozen at 2.
        rr_out_ready = 1'b0;
        rr_in_valid  = 3'b111;
        @(negedge clk);
        check("single_out_valid", 32'(rr_out_valid), 1);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            if (i > 0) @(negedge clk);
            check("stall_data", rr_out_data, 9);
            check("stall_sel", 32'(rr_out_sel), 1);
            check("stall_in_ready", 32'(rr_in_ready), 0);
        end
        step();
        rr_out_ready = 1'b1;
        rr_q.push_back('{data: 32'd12, sel: 2'd2});
        @(negedge clk);
        check("after_stall_grant", 32'(rr_in_ready), 4);

        // Rotation with all channels valid.
        for (int i = 0; i < 6; i++) begin
            step();
            rr_q.push_back('{data: dv[i % 3], sel: 2'(i % 3)});
            @(negedge clk);
            check("rot_in_ready", 32'(rr_in_ready), 32'(1 << (i % 3)));
        end
        step();
        rr_in_valid = 3'b000;
        @(negedge clk);
        check("drain_in_ready", 32'(rr_in_ready), 0);
        step();
        @(negedge clk);
        check("drain_out_valid", 32'(rr_out_valid), 0);
        check("drain_hold_data", rr_out_data, 12);
        check("drain_hold_sel", 32'(rr_out_sel), 2);

        // Async reset while a word is held; that word is discarded, never pushed.
        step();
        rr_in_valid = 3'b111;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_out_valid", 32'(rr_out_valid), 0);
        check("async_out_data", rr_out_data, 0);
        check("async_in_ready", 32'(rr_in_ready), 0);
        step();
        step();
        rst_n = 1'b1;
        rr_q.push_back('{data: 32'd5, sel: 2'd0});
        @(negedge clk);
        check("post_reset_grant", 32'(rr_in_ready), 1);
        step();
        rr_in_valid = 3'b000;
        step();

        // Fixed priority instance.
        fx_in_valid  = 3'b111;
        fx_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            fx_q.push_back('{data: 32'd5, sel: 2'd0});
            @(negedge clk);
            check("fx_all_in_ready", 32'(fx_in_ready), 1);
            step();
        end
        fx_in_valid = 3'b110;
        fx_q.push_back('{data: 32'd9, sel: 2'd1});
        @(negedge clk);
        check("fx_110_in_ready", 32'(fx_in_ready), 2);
        step();
        fx_in_valid = 3'b100;
        fx_q.push_back('{data: 32'd12, sel: 2'd2});
        @(negedge clk);
        check("fx_100_in_ready", 32'(fx_in_ready), 4);
        step();
        fx_in_valid  = 3'b011;
        fx_out_ready = 1'b0;
        @(negedge clk);
        check("fx_stall_in_ready", 32'(fx_in_ready), 0);
        check("fx_stall_data", fx_out_data, 12);
        step();
        fx_out_ready = 1'b1;
        fx_q.push_back('{data: 32'd5, sel: 2'd0});
        @(negedge clk);
        check("fx_resume_in_ready", 32'(fx_in_ready), 1);
        step();
        fx_in_valid = 3'b000;
        step();
        step();

        check("rr_queue_empty", 32'(rr_q.size()), 0);
        check("fx_queue_empty", 32'(fx_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
